// File: rtl/au_sum_zero_ser_if.sv
// Handshake/operand bundle for the slice-serial sum-zero sequencer.
// The master side is the producer/consumer pair; the slave side is the sequencer.
interface au_sum_zero_ser_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NSLICE = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH*NSLICE-1:0]  a;
  logic [WIDTH*NSLICE-1:0]  b;
  logic                     ci;
  logic                     out_valid;
  logic                     out_ready;
  logic                     z;
  logic                     co;
  logic                     busy;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, z, co, busy
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, z, co, busy
  );
endinterface

// File: rtl/au_sum_zero_ser.sv
// Slice-serial sum-zero detector: reports whether a+b+ci is all-zeros, LSB slice first.
// Optional AU_SUM_ZERO_SER_EARLY_EXIT_EN stops at the first non-zero slice.
module au_sum_zero_ser #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NSLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  au_sum_zero_ser_if.slave bus
);
  localparam int unsigned CntW = $clog2(NSLICE);
  localparam int unsigned OpW  = WIDTH * NSLICE;
  localparam logic [CntW-1:0] LastCnt = CntW'(NSLICE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [OpW-1:0]  r_a;
  logic [OpW-1:0]  r_b;
  logic [CntW-1:0] r_cnt;
  logic            r_carry;
  logic            r_zacc;
  logic            r_z;
  logic            r_co;

  logic [WIDTH-1:0] w_ak;
  logic [WIDTH-1:0] w_bk;
  logic [WIDTH-1:0] w_cvec;
  logic             w_zs;
  logic             w_cout;
  logic             w_last;
  logic             w_exit;
  logic             w_co_fin;
  logic             w_accept;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;

  assign w_ak = r_a[int'(r_cnt) * WIDTH +: WIDTH];
  assign w_bk = r_b[int'(r_cnt) * WIDTH +: WIDTH];

  // With all lower sum bits zero, the carry into bit i is a[i-1]|b[i-1].
  assign w_cvec = WIDTH'({(w_ak | w_bk), r_carry});
  assign w_zs   = &(~(w_ak ^ w_bk ^ w_cvec));
  assign w_cout = ({1'b0, w_ak} + {1'b0, w_bk} + {{WIDTH{1'b0}}, r_carry})
                  > {1'b0, {WIDTH{1'b1}}};
  assign w_last = (r_cnt == LastCnt);

`ifdef AU_SUM_ZERO_SER_EARLY_EXIT_EN
  assign w_exit   = w_last | ~w_zs;
  assign w_co_fin = w_cout & w_zs;
`else
  assign w_exit   = w_last;
  assign w_co_fin = w_cout;
`endif

  assign w_accept = (r_state == StIdle) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (bus.in_valid)  w_state_d = StRun;
      StRun:   if (w_exit)        w_state_d = StDone;
      StDone:  if (bus.out_ready) w_state_d = StIdle;
      default:                    w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == StIdle);
    w_out_valid = (r_state == StDone);
    w_busy      = (r_state != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
      r_z     <= 1'b0;
      r_co    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= bus.a;
        r_b     <= bus.b;
        r_carry <= bus.ci;
        r_cnt   <= '0;
        r_zacc  <= 1'b1;
      end else if (r_state == StRun) begin
        r_carry <= w_cout;
        r_zacc  <= r_zacc & w_zs;
        // Counter parks on the last slice instead of wrapping.
        if (!w_last) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_exit) begin
          r_z  <= r_zacc & w_zs;
          r_co <= w_co_fin;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.z         = r_z;
  assign bus.co        = r_co;
endmodule
